// File: rtl/matmul2_chain_core.sv
// 2mm compute engine: tmp = alpha*A*B, then D = beta*D + tmp*C, all operands held
// in one external scratchpad reached through two 1-cycle-latency memory ports.
module matmul2_chain_core #(
    parameter int NI       = 16,
    parameter int NK       = 16,
    parameter int NJ       = 16,
    parameter int NL       = 16,
    parameter int ADDR_WID = 14,
    parameter int DATA_WID = 32
) (
    input  logic                ap_clk,
    input  logic                ap_rst,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    output logic                ap_ready,
    output logic [ADDR_WID-1:0] indata_address0,
    output logic                indata_ce0,
    output logic                indata_we0,
    output logic [DATA_WID-1:0] indata_d0,
    input  logic [DATA_WID-1:0] indata_q0,
    output logic [ADDR_WID-1:0] indata_address1,
    output logic                indata_ce1,
    output logic                indata_we1,
    output logic [DATA_WID-1:0] indata_d1,
    input  logic [DATA_WID-1:0] indata_q1
);
    localparam int A_BASE = 16;
    localparam int B_BASE = A_BASE + NI * NK;
    localparam int T_BASE = B_BASE + NK * NJ;
    localparam int C_BASE = T_BASE + NI * NJ;
    localparam int D_BASE = C_BASE + NJ * NL;
    localparam int IW     = 8;
    localparam logic [IW-1:0] ONE    = IW'(1);
    localparam logic [IW-1:0] I_LAST = IW'(NI - 1);
    localparam logic [IW-1:0] J_LAST = IW'(NJ - 1);
    localparam logic [IW-1:0] K_LAST = IW'(NK - 1);
    localparam logic [IW-1:0] L_LAST = IW'(NL - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PARAM_RD, S_PARAM_LAT, S_P1_RD, S_P1_MAC, S_P1_WR,
        S_P2_DRD, S_P2_DLAT, S_P2_RD, S_P2_MAC, S_P2_WR, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IW-1:0]         i_q, i_d, j_q, j_d, k_q, k_d, l_q, l_d;
    logic [DATA_WID-1:0]   alpha_q, alpha_d, beta_q, beta_d, acc_q, acc_d;
    logic                  ap_idle_q, ap_idle_d, ap_done_q, ap_done_d;
    logic [ADDR_WID-1:0]   addr0_q, addr0_d, addr1_q, addr1_d;
    logic                  ce0_q, ce0_d, we0_q, we0_d, ce1_q, ce1_d;
    logic [DATA_WID-1:0]   d0_q, d0_d;

    function automatic logic [ADDR_WID-1:0] elem_addr(input int base, input logic [IW-1:0] r,
                                                      input int cols, input logic [IW-1:0] c);
        return ADDR_WID'(base + int'(r) * cols + int'(c));
    endfunction

    // Sequencing: state transitions, loop indices and the accumulator datapath.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        l_d     = l_q;
        alpha_d = alpha_q;
        beta_d  = beta_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (ap_start) begin
                    state_d = S_PARAM_RD;
                    i_d = '0; j_d = '0; k_d = '0; l_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PARAM_RD: state_d = S_PARAM_LAT;
            S_PARAM_LAT: begin
                alpha_d = indata_q0;
                beta_d  = indata_q1;
                acc_d   = '0;
                state_d = S_P1_RD;
            end
            S_P1_RD: state_d = S_P1_MAC;
            S_P1_MAC: begin
                acc_d = acc_q + alpha_q * indata_q0 * indata_q1;
                if (k_q != K_LAST) begin
                    k_d = k_q + ONE;
                    state_d = S_P1_RD;
                end else begin
                    state_d = S_P1_WR;
                end
            end
            S_P1_WR: begin
                acc_d = '0;
                k_d   = '0;
                if (j_q != J_LAST) begin
                    j_d = j_q + ONE;
                    state_d = S_P1_RD;
                end else if (i_q != I_LAST) begin
                    j_d = '0;
                    i_d = i_q + ONE;
                    state_d = S_P1_RD;
                end else begin
                    j_d = '0; i_d = '0; l_d = '0;
                    state_d = S_P2_DRD;
                end
            end
            S_P2_DRD: state_d = S_P2_DLAT;
            S_P2_DLAT: begin
                acc_d = indata_q0 * beta_q;
                j_d   = '0;
                state_d = S_P2_RD;
            end
            S_P2_RD: state_d = S_P2_MAC;
            S_P2_MAC: begin
                acc_d = acc_q + indata_q0 * indata_q1;
                if (j_q != J_LAST) begin
                    j_d = j_q + ONE;
                    state_d = S_P2_RD;
                end else begin
                    state_d = S_P2_WR;
                end
            end
            S_P2_WR: begin
                if (l_q != L_LAST) begin
                    l_d = l_q + ONE;
                    state_d = S_P2_DRD;
                end else if (i_q != I_LAST) begin
                    l_d = '0;
                    i_d = i_q + ONE;
                    state_d = S_P2_DRD;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Port and handshake outputs, decoded from the next state so they register in step with it.
    always_comb begin
        ap_idle_d = 1'b0;
        ap_done_d = 1'b0;
        addr0_d   = '0;
        addr1_d   = '0;
        ce0_d     = 1'b0;
        ce1_d     = 1'b0;
        we0_d     = 1'b0;
        d0_d      = '0;
        case (state_d)
            S_IDLE: ap_idle_d = 1'b1;
            S_DONE: ap_done_d = 1'b1;
            S_PARAM_RD: begin
                ce0_d   = 1'b1;
                ce1_d   = 1'b1;
                addr1_d = ADDR_WID'(1);
            end
            S_P1_RD: begin
                ce0_d   = 1'b1;
                ce1_d   = 1'b1;
                addr0_d = elem_addr(A_BASE, i_d, NK, k_d);
                addr1_d = elem_addr(B_BASE, k_d, NJ, j_d);
            end
            S_P1_WR: begin
                ce0_d   = 1'b1;
                we0_d   = 1'b1;
                addr0_d = elem_addr(T_BASE, i_d, NJ, j_d);
                d0_d    = acc_d;
            end
            S_P2_DRD: begin
                ce0_d   = 1'b1;
                addr0_d = elem_addr(D_BASE, i_d, NL, l_d);
            end
            S_P2_RD: begin
                ce0_d   = 1'b1;
                ce1_d   = 1'b1;
                addr0_d = elem_addr(T_BASE, i_d, NJ, j_d);
                addr1_d = elem_addr(C_BASE, j_d, NL, l_d);
            end
            S_P2_WR: begin
                ce0_d   = 1'b1;
                we0_d   = 1'b1;
                addr0_d = elem_addr(D_BASE, i_d, NL, l_d);
                d0_d    = acc_d;
            end
            default: ap_idle_d = 1'b0;
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            l_q       <= '0;
            alpha_q   <= '0;
            beta_q    <= '0;
            acc_q     <= '0;
            ap_idle_q <= 1'b1;
            ap_done_q <= 1'b0;
            addr0_q   <= '0;
            addr1_q   <= '0;
            ce0_q     <= 1'b0;
            ce1_q     <= 1'b0;
            we0_q     <= 1'b0;
            d0_q      <= '0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            k_q       <= k_d;
            l_q       <= l_d;
            alpha_q   <= alpha_d;
            beta_q    <= beta_d;
            acc_q     <= acc_d;
            ap_idle_q <= ap_idle_d;
            ap_done_q <= ap_done_d;
            addr0_q   <= addr0_d;
            addr1_q   <= addr1_d;
            ce0_q     <= ce0_d;
            ce1_q     <= ce1_d;
            we0_q     <= we0_d;
            d0_q      <= d0_d;
        end
    end

    assign ap_idle         = ap_idle_q;
    assign ap_done         = ap_done_q;
    assign ap_ready        = ap_done_q;
    assign indata_address0 = addr0_q;
    assign indata_ce0      = ce0_q;
    assign indata_we0      = we0_q;
    assign indata_d0       = d0_q;
    assign indata_address1 = addr1_q;
    assign indata_ce1      = ce1_q;
    assign indata_we1      = 1'b0;
    assign indata_d1       = '0;
endmodule

// File: tb/tb_matmul2_chain_core.sv
// Directed bench for matmul2_chain_core with a 2-port scratchpad model and a port monitor.
module tb_matmul2_chain_core;
    localparam int A_BASE = 16;
    localparam int B_BASE = 272;
    localparam int T_BASE = 528;
    localparam int C_BASE = 784;
    localparam int D_BASE = 1040;
    localparam int LAT    = 17411;

    logic        clk = 1'b0;
    logic        ap_rst, ap_start, ap_done, ap_idle, ap_ready;
    logic [13:0] addr0, addr1;
    logic        ce0, we0, ce1, we1;
    logic [31:0] d0, d1, q0, q1;

    logic [31:0] mem [0:16383];
    logic        tb_we = 1'b0;
    logic [13:0] tb_addr = 14'd0;
    logic [31:0] tb_data = 32'd0;

    int n_chk = 0;
    int n_pass = 0;
    int viol = 0;

    always #5 clk = ~clk;

    matmul2_chain_core dut (
        .ap_clk(clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .indata_address0(addr0), .indata_ce0(ce0), .indata_we0(we0),
        .indata_d0(d0), .indata_q0(q0),
        .indata_address1(addr1), .indata_ce1(ce1), .indata_we1(we1),
        .indata_d1(d1), .indata_q1(q1)
    );

    // Scratchpad: 1-cycle read latency on both ports; bench loads take priority over DUT writes.
    always @(posedge clk) begin
        if (ce0 && !we0) q0 <= mem[addr0];
        if (ce1 && !we1) q1 <= mem[addr1];
        if (tb_we) mem[tb_addr] <= tb_data;
        else if (ce0 && we0) mem[addr0] <= d0;
    end

    function automatic bit rd_ok(input logic [13:0] a);
        return (a <= 14'd1) || (a >= 14'd16 && a <= 14'd1295);
    endfunction

    // Port protocol monitor.
    always @(negedge clk) begin
        if (!ap_rst) begin
            if (we1) viol <= viol + 1;
            if (ce0 && we0) begin
                if (!((addr0 >= 14'd528 && addr0 <= 14'd783) || (addr0 >= 14'd1040 && addr0 <= 14'd1295)))
                    viol <= viol + 1;
                if (ce1) viol <= viol + 1;
            end
            if (ce0 && !we0 && !rd_ok(addr0)) viol <= viol + 1;
            if (ce1 && !rd_ok(addr1)) viol <= viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic mem_wr(input int a, input logic [31:0] v);
        tb_we = 1'b1;
        tb_addr = 14'(a);
        tb_data = v;
        @(posedge clk);
        #1;
        tb_we = 1'b0;
    endtask

    // mode 0 basic, 1 identity, 2 wraparound
    task automatic load(input int mode, input logic [31:0] alpha, input logic [31:0] beta);
        logic [31:0] av, bv, cv, dv;
        mem_wr(0, alpha);
        mem_wr(1, beta);
        for (int idx = 0; idx < 256; idx++) begin
            case (mode)
                1: begin
                    av = (idx / 16 == idx % 16) ? 32'd1 : 32'd0;
                    bv = 32'(idx);
                    cv = av;
                    dv = 32'd7;
                end
                2: begin
                    av = 32'h0001_0000; bv = 32'h0001_0000; cv = 32'd1; dv = 32'd9;
                end
                default: begin
                    av = 32'd1; bv = 32'd1; cv = 32'd1; dv = 32'd5;
                end
            endcase
            mem_wr(A_BASE + idx, av);
            mem_wr(B_BASE + idx, bv);
            mem_wr(T_BASE + idx, 32'hDEAD_BEEF);
            mem_wr(C_BASE + idx, cv);
            mem_wr(D_BASE + idx, dv);
        end
    endtask

    // Raise start, count cycles from the sampling IDLE cycle to ap_done.
    task automatic run_op(input bit hold);
        int cnt;
        @(negedge clk);
        ap_start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) ap_start = 1'b0;
        chk("idle_busy", {31'd0, ap_idle}, 32'd0);
        cnt = 1;
        while (!ap_done && cnt < 40000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("latency", cnt, LAT);
        chk("ready_with_done", {31'd0, ap_ready}, 32'd1);
        chk("idle_in_done", {31'd0, ap_idle}, 32'd0);
    endtask

    task automatic check_results(input string tag, input int mode);
        logic [31:0] te, de;
        int bad_t, bad_d;
        bad_t = 0;
        bad_d = 0;
        for (int idx = 0; idx < 256; idx++) begin
            case (mode)
                1: begin te = 32'(idx); de = 32'(idx); end
                2: begin te = 32'd0; de = 32'd9; end
                3: begin te = 32'd32; de = 32'd2093; end
                default: begin te = 32'd32; de = 32'd527; end
            endcase
            if (mem[T_BASE + idx] !== te) begin
                if (bad_t == 0) chk({tag, "_tmp_first"}, mem[T_BASE + idx], te);
                bad_t++;
            end
            if (mem[D_BASE + idx] !== de) begin
                if (bad_d == 0) chk({tag, "_d_first"}, mem[D_BASE + idx], de);
                bad_d++;
            end
        end
        chk({tag, "_tmp_bad"}, bad_t, 0);
        chk({tag, "_d_bad"}, bad_d, 0);
        chk({tag, "_tmp00"}, mem[T_BASE], (mode == 1 || mode == 2) ? 32'd0 : 32'd32);
        chk({tag, "_d_last"}, mem[D_BASE + 255],
            (mode == 1) ? 32'd255 : (mode == 2) ? 32'd9 : (mode == 3) ? 32'd2093 : 32'd527);
    endtask

    initial begin
        int cnt;
        ap_rst = 1'b1;
        ap_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_idle", {31'd0, ap_idle}, 32'd1);
        chk("rst_done", {31'd0, ap_done}, 32'd0);
        chk("rst_ready", {31'd0, ap_ready}, 32'd0);
        chk("rst_ce", {30'd0, ce0, ce1}, 32'd0);
        chk("rst_we", {30'd0, we0, we1}, 32'd0);
        chk("rst_addr", {4'd0, addr0, addr1}, 32'd0);
        chk("rst_d0", d0, 32'd0);
        ap_rst = 1'b0;

        // Basic case with start held high: restart straight out of DONE.
        load(0, 32'd2, 32'd3);
        run_op(1'b1);
        check_results("basic", 0);
        @(posedge clk);
        #1;
        chk("done_single", {31'd0, ap_done}, 32'd0);
        chk("restart_busy", {31'd0, ap_idle}, 32'd0);
        chk("restart_ce", {30'd0, ce0, ce1}, 32'd3);
        cnt = 1;
        while (!ap_done && cnt < 40000) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        chk("restart_latency", cnt, LAT);
        ap_start = 1'b0;
        check_results("restart", 3);
        @(posedge clk);
        #1;
        chk("idle_after_done", {31'd0, ap_idle}, 32'd1);

        // Identity matrices.
        load(1, 32'd1, 32'd0);
        run_op(1'b0);
        check_results("ident", 1);
        @(posedge clk);
        #1;
        chk("ident_done_pulse", {31'd0, ap_done}, 32'd0);
        chk("ident_idle", {31'd0, ap_idle}, 32'd1);

        // Reset part-way through a run.
        @(negedge clk);
        ap_start = 1'b1;
        @(posedge clk);
        #1;
        ap_start = 1'b0;
        repeat (4999) @(posedge clk);
        #1;
        ap_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_idle", {31'd0, ap_idle}, 32'd1);
        chk("midrst_ce", {30'd0, ce0, ce1}, 32'd0);
        chk("midrst_done", {31'd0, ap_done}, 32'd0);
        ap_rst = 1'b0;

        // Fresh run after the reset: 2^48 wraps to zero.
        load(2, 32'h0001_0000, 32'd1);
        run_op(1'b0);
        check_results("wrap", 2);

        chk("proto_viol", viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
